pll_rst_seq: RTL and testbench



---
 rtl/pll_rst_seq.sv | 197 +++++++++++++++++++
 tb/tb_pll_rst_seq.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_rst_seq.sv
// PLL bring-up and reset sequencer: pulses the PLL reset, debounces lock,
// retries on timeout and releases N_CH domain resets in staggered order.
module pll_rst_seq #(
  parameter int N_CH      = 3,
  parameter int RST_PULSE = 16,
  parameter int LOCK_CNT  = 1024,
  parameter int TIMEOUT   = 65536,
  parameter int STAGGER   = 64,
  parameter int MAX_RETRY = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pll_lock,
  input  logic            soft_rst,
  output logic            pll_rst,
  output logic            pll_pwd,
  output logic [N_CH-1:0] ch_rst_n,
  output logic            ready,
  output logic            fail,
  output logic            lock_lost,
  output logic [3:0]      retry_cnt
);

  localparam int PW = $clog2(RST_PULSE) + 1;
  localparam int LW = $clog2(LOCK_CNT) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(STAGGER) + 1;

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_DEB,
    S_REL,
    S_RUN,
    S_FAIL
  } state_e;

  state_e          st_q, st_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [LW-1:0]   dcnt_q, dcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [SW-1:0]   scnt_q, scnt_d;
  logic            sync1_q, sync2_q;
  logic            lock_s;
  logic            pll_rst_q, pll_rst_d;
  logic            pwd_q, pwd_d;
  logic [N_CH-1:0] ch_q, ch_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            lost_q, lost_d;
  logic [3:0]      retry_q, retry_d;
  logic            restart;
  logic            lost;

  assign lock_s = sync2_q;

  always_comb begin
    st_d    = st_q;
    pcnt_d  = pcnt_q;
    dcnt_d  = dcnt_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    ch_d    = ch_q;
    ready_d = ready_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    restart = 1'b0;
    lost    = 1'b0;
    if (soft_rst) begin
      restart = 1'b1;
      retry_d = '0;
    end else begin
      unique case (st_q)
        S_RESET: begin
          if (pcnt_q == PW'(RST_PULSE - 1)) begin
            st_d   = S_WAIT;
            tcnt_d = '0;
            dcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        S_WAIT, S_DEB: begin
          if (tcnt_q != TW'(TIMEOUT))
            tcnt_d = tcnt_q + TW'(1);
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            if (retry_q != 4'hf)
              retry_d = retry_q + 4'd1;
            if (MAX_RETRY != 0 && retry_d == 4'(MAX_RETRY))
              st_d = S_FAIL;
            else
              restart = 1'b1;
          end else if (!lock_s) begin
            st_d   = S_WAIT;
            dcnt_d = '0;
          end else if (dcnt_q == LW'(LOCK_CNT - 1)) begin
            // Channel 0 is released on entry to RELEASE.
            ch_d    = '0;
            ch_d[0] = 1'b1;
            scnt_d  = '0;
            if (N_CH == 1) begin
              st_d    = S_RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end else begin
              st_d = S_REL;
            end
          end else begin
            st_d   = S_DEB;
            dcnt_d = dcnt_q + LW'(1);
          end
        end
        S_REL: begin
          if (!lock_s) begin
            lost = 1'b1;
          end else if (scnt_q == SW'(STAGGER - 1)) begin
            ch_d   = (ch_q << 1) | N_CH'(1);
            scnt_d = '0;
            if (ch_d[N_CH-1]) begin
              st_d    = S_RUN;
              ready_d = 1'b1;
              retry_d = '0;
            end
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
        S_RUN: begin
          if (!lock_s)
            lost = 1'b1;
        end
        S_FAIL: ;
        default: restart = 1'b1;
      endcase
    end
    if (lost) begin
      restart = 1'b1;
      lost_d  = 1'b1;
    end
    if (restart) begin
      st_d    = S_RESET;
      pcnt_d  = '0;
      ch_d    = '0;
      ready_d = 1'b0;
    end
    if (st_d == S_FAIL) begin
      ch_d    = '0;
      ready_d = 1'b0;
    end
    pll_rst_d = (st_d == S_RESET) || (st_d == S_FAIL);
    pwd_d     = (st_d == S_FAIL);
    fail_d    = (st_d == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q      <= S_RESET;
      pcnt_q    <= '0;
      dcnt_q    <= '0;
      tcnt_q    <= '0;
      scnt_q    <= '0;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      pll_rst_q <= 1'b1;
      pwd_q     <= 1'b0;
      ch_q      <= '0;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      lost_q    <= 1'b0;
      retry_q   <= '0;
    end else begin
      st_q      <= st_d;
      pcnt_q    <= pcnt_d;
      dcnt_q    <= dcnt_d;
      tcnt_q    <= tcnt_d;
      scnt_q    <= scnt_d;
      sync1_q   <= pll_lock;
      sync2_q   <= sync1_q;
      pll_rst_q <= pll_rst_d;
      pwd_q     <= pwd_d;
      ch_q      <= ch_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      lost_q    <= lost_d;
      retry_q   <= retry_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign pll_pwd   = pwd_q;
  assign ch_rst_n  = ch_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign lock_lost = lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: a timeline model checked every cycle on two
// configurations, plus hand-computed cycle expectations.
module tb_pll_rst_seq;

  localparam int RP = 4;
  localparam int LC = 8;
  localparam int TO = 100;
  localparam int ST = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       soft_rst = 1'b0;

  logic       a_pll_rst, a_pwd, a_ready, a_fail, a_lost;
  logic [2:0] a_ch;
  logic [3:0] a_retry;
  logic       b_pll_rst, b_pwd, b_ready, b_fail, b_lost;
  logic [0:0] b_ch;
  logic [3:0] b_retry;

  pll_rst_seq #(
    .N_CH(3), .RST_PULSE(RP), .LOCK_CNT(LC),
    .TIMEOUT(TO), .STAGGER(ST), .MAX_RETRY(2)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .soft_rst(soft_rst), .pll_rst(a_pll_rst), .pll_pwd(a_pwd),
    .ch_rst_n(a_ch), .ready(a_ready), .fail(a_fail),
    .lock_lost(a_lost), .retry_cnt(a_retry)
  );

  pll_rst_seq #(
    .N_CH(1), .RST_PULSE(RP), .LOCK_CNT(LC),
    .TIMEOUT(TO), .STAGGER(ST), .MAX_RETRY(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .soft_rst(soft_rst), .pll_rst(b_pll_rst), .pll_pwd(b_pwd),
    .ch_rst_n(b_ch), .ready(b_ready), .fail(b_fail),
    .lock_lost(b_lost), .retry_cnt(b_retry)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int t0 = 0;
  bit chk_en = 0;

  task automatic chk(string nm, int got, int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
               nm, got, exp, cyc - t0);
    end
  endtask

  // Timeline model: when the current sequence started, when release
  // began, length of the current lock run, retries, failure latch.
  int p_n[2]  = '{3, 1};
  int p_mr[2] = '{2, 0};
  int m_seq[2], m_rel[2], m_run[2], m_retry[2];
  bit m_relsd[2], m_failed[2], m_lost[2];
  bit h1 = 0, h2 = 0;

  task automatic restart_seq(int i);
    m_seq[i]   = cyc + 1;
    m_relsd[i] = 0;
    m_run[i]   = 0;
  endtask

  task automatic model_step(int i, bit ls);
    int w, rdy;
    m_lost[i] = 0;
    w   = m_seq[i] + RP;
    rdy = m_rel[i] + ST * (p_n[i] - 1);
    if (!rst_n || soft_rst) begin
      restart_seq(i);
      m_retry[i]  = 0;
      m_failed[i] = 0;
    end else if (m_failed[i]) begin
      m_lost[i] = 0;
    end else if (m_relsd[i]) begin
      if (!ls) begin
        m_lost[i] = 1;
        restart_seq(i);
      end else if (cyc + 1 == rdy) begin
        m_retry[i] = 0;
      end
    end else if (cyc >= w) begin
      if (cyc == w + TO - 1) begin
        m_retry[i] = (m_retry[i] < 15) ? m_retry[i] + 1 : 15;
        if (p_mr[i] != 0 && m_retry[i] == p_mr[i])
          m_failed[i] = 1;
        else
          restart_seq(i);
      end else begin
        m_run[i] = ls ? m_run[i] + 1 : 0;
        if (m_run[i] == LC) begin
          m_relsd[i] = 1;
          m_rel[i]   = cyc + 1;
          if (p_n[i] == 1)
            m_retry[i] = 0;
        end
      end
    end
  endtask

  initial begin
    bit ls;
    forever begin
      @(posedge clk);
      ls = h2;
      if (!rst_n) begin
        h1 = 0;
        h2 = 0;
      end else begin
        h2 = h1;
        h1 = pll_lock;
      end
      model_step(0, ls);
      model_step(1, ls);
      cyc++;
    end
  end

  task automatic cmp(int i, int pr, int pw, int ch, int rd,
                     int fl, int lo, int rt);
    int e_ch, e_rd, e_pr;
    string s;
    s = (i == 0) ? "a." : "b.";
    e_ch = 0;
    e_rd = 0;
    e_pr = 0;
    if (m_failed[i]) begin
      e_pr = 1;
    end else if (m_relsd[i]) begin
      for (int k = 0; k < p_n[i]; k++)
        if (cyc >= m_rel[i] + ST * k) e_ch |= (1 << k);
      e_rd = (cyc >= m_rel[i] + ST * (p_n[i] - 1)) ? 1 : 0;
    end else begin
      e_pr = (cyc < m_seq[i] + RP) ? 1 : 0;
    end
    chk({s, "pll_rst"}, pr, e_pr);
    chk({s, "pll_pwd"}, pw, int'(m_failed[i]));
    chk({s, "ch_rst_n"}, ch, e_ch);
    chk({s, "ready"}, rd, e_rd);
    chk({s, "fail"}, fl, int'(m_failed[i]));
    chk({s, "lock_lost"}, lo, int'(m_lost[i]));
    chk({s, "retry_cnt"}, rt, m_retry[i]);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        cmp(0, a_pll_rst, a_pwd, a_ch, a_ready, a_fail, a_lost, a_retry);
        cmp(1, b_pll_rst, b_pwd, b_ch, b_ready, b_fail, b_lost, b_retry);
      end
    end
  end

  task automatic at(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(int t);
    at(t);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    soft_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1;
    rst_n  = 1'b1;
    t0     = cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, tl;
    // Clean bring-up
    do_reset();
    at_neg(t0);
    chk("rst.pll_rst", a_pll_rst, 1);
    chk("rst.ch", a_ch, 0);
    chk("rst.retry", a_retry, 0);
    at_neg(t0 + 3);
    chk("clean.pll_rst3", a_pll_rst, 1);
    at_neg(t0 + 4);
    chk("clean.pll_rst4", a_pll_rst, 0);
    at(t0 + 10);
    pll_lock = 1'b1;
    at_neg(t0 + 19);
    chk("clean.ch19", a_ch, 0);
    at_neg(t0 + 20);
    chk("clean.ch20", a_ch, 1);
    chk("clean.b_ready20", b_ready, 1);
    chk("clean.b_ch20", b_ch, 1);
    at_neg(t0 + 25);
    chk("clean.ch25", a_ch, 3);
    at_neg(t0 + 29);
    chk("clean.ready29", a_ready, 0);
    at_neg(t0 + 30);
    chk("clean.ch30", a_ch, 7);
    chk("clean.ready30", a_ready, 1);
    chk("clean.retry30", a_retry, 0);

    // Glitchy lock
    do_reset();
    at(t0 + 10);
    pll_lock = 1'b1;
    at(t0 + 15);
    pll_lock = 1'b0;
    at(t0 + 16);
    pll_lock = 1'b1;
    at_neg(t0 + 25);
    chk("glitch.ch25", a_ch, 0);
    at_neg(t0 + 26);
    chk("glitch.ch26", a_ch, 1);
    chk("glitch.retry", a_retry, 0);
    at_neg(t0 + 36);
    chk("glitch.ready36", a_ready, 1);

    // Timeout and fail
    do_reset();
    at_neg(t0 + 103);
    chk("to.pll_rst103", a_pll_rst, 0);
    at_neg(t0 + 104);
    chk("to.pll_rst104", a_pll_rst, 1);
    chk("to.retry104", a_retry, 1);
    at_neg(t0 + 207);
    chk("to.fail207", a_fail, 0);
    at_neg(t0 + 208);
    chk("to.fail208", a_fail, 1);
    chk("to.pwd208", a_pwd, 1);
    chk("to.retry208", a_retry, 2);
    chk("to.b_retry208", b_retry, 2);
    at_neg(t0 + 1208);
    chk("to.fail1208", a_fail, 1);
    chk("to.pll_rst1208", a_pll_rst, 1);

    // soft_rst recovery from FAIL
    ts = t0 + 1210;
    at(ts);
    soft_rst = 1'b1;
    at(ts + 1);
    soft_rst = 1'b0;
    @(negedge clk);
    chk("soft.fail", a_fail, 0);
    chk("soft.pwd", a_pwd, 0);
    chk("soft.retry", a_retry, 0);
    chk("soft.pll_rst", a_pll_rst, 1);
    chk("soft.b_retry", b_retry, 0);
    at(ts + 11);
    pll_lock = 1'b1;
    at_neg(ts + 30);
    chk("soft.ready30", a_ready, 0);
    at_neg(ts + 31);
    chk("soft.ready31", a_ready, 1);

    // Lock loss in RUN
    tl = ts + 40;
    at(tl);
    pll_lock = 1'b0;
    at(tl + 1);
    pll_lock = 1'b1;
    at_neg(tl + 2);
    chk("loss.ready2", a_ready, 1);
    chk("loss.lost2", a_lost, 0);
    at_neg(tl + 3);
    chk("loss.lost3", a_lost, 1);
    chk("loss.ch3", a_ch, 0);
    chk("loss.pll_rst3", a_pll_rst, 1);
    chk("loss.b_lost3", b_lost, 1);
    at_neg(tl + 4);
    chk("loss.lost4", a_lost, 0);
    at_neg(tl + 6);
    chk("loss.pll_rst6", a_pll_rst, 1);
    at_neg(tl + 7);
    chk("loss.pll_rst7", a_pll_rst, 0);
    at_neg(tl + 14);
    chk("loss.b_ready14", b_ready, 0);
    at_neg(tl + 15);
    chk("loss.b_ready15", b_ready, 1);
    at_neg(tl + 24);
    chk("loss.ready24", a_ready, 0);
    at_neg(tl + 25);
    chk("loss.ready25", a_ready, 1);

    // soft_rst coincident with timeout expiry, then saturation
    do_reset();
    at(t0 + 103);
    soft_rst = 1'b1;
    at(t0 + 104);
    soft_rst = 1'b0;
    @(negedge clk);
    chk("prio.retry104", a_retry, 0);
    chk("prio.fail104", a_fail, 0);
    chk("prio.pll_rst104", a_pll_rst, 1);
    at_neg(t0 + 208);
    chk("prio.retry208", a_retry, 1);
    chk("prio.fail208", a_fail, 0);
    at_neg(t0 + 2100);
    chk("sat.b_retry", b_retry, 15);
    chk("sat.b_fail", b_fail, 0);
    chk("sat.a_fail", a_fail, 1);
    chk("sat.a_retry", a_retry, 2);

    at(t0 + 2110);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
